// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencer between the processor X stage and the shared
// multiply/divide unit. It takes one request at a time, holds its operands,
// issues a single start pulse and stalls the pipeline until the unit reports
// ready or the cycle budget runs out. It then issues one writeback. On an
// exception or a timeout, that writeback goes to the status register.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT       = 40,     // 2..63 cycles spent in BUSY
  parameter logic [4:0]  EXC_RD        = 5'd30,
  parameter logic [31:0] MULT_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE  = 32'd5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] req_opA,
  input  logic [31:0] req_opB,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout_flag
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The count of the final BUSY cycle before the forced timeout.
  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;
  logic        timeout_flag_q, timeout_flag_d;

  // Next-state logic: request acceptance, the BUSY cycle count, and result capture.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    rd_d           = rd_q;
    res_d          = res_q;
    exc_d          = exc_q;
    timeout_flag_d = timeout_flag_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          op_d    = req_op;
          opa_d   = req_opA;
          opb_d   = req_opB;
          rd_d    = req_rd;
          state_d = S_START;
        end
      end
      S_START: begin
        // The unit is restarting here, so a ready flag in this cycle is stale.
        cnt_d   = '0;
        state_d = flush ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (md_resultRDY) begin
            // If ready and timeout fall in the same cycle, the real result is written.
            res_d   = md_result;
            exc_d   = md_exception;
            state_d = S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            exc_d          = 1'b1;
            timeout_flag_d = 1'b1;
            state_d        = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;  // S_DONE: writeback lasts one cycle
    endcase
  end

  // State registers; reset clears everything, even in the middle of an operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      op_q           <= 1'b0;
      opa_q          <= '0;
      opb_q          <= '0;
      rd_q           <= '0;
      res_q          <= '0;
      exc_q          <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values from before the edge.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      rd_q           <= rd_d;
      res_q          <= res_d;
      exc_q          <= exc_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  // Outputs: start pulses only in START; writeback only in an unflushed DONE cycle.
  // Stall is gated by reset so that all outputs are low while reset is held.
  always_comb begin
    stall        = reset_n &&
                   (((state_q == S_IDLE) && req_valid && !flush) ||
                    (state_q == S_START) || (state_q == S_BUSY));
    md_ctrl_MULT = (state_q == S_START) && !op_q;
    md_ctrl_DIV  = (state_q == S_START) &&  op_q;
    md_operandA  = opa_q;
    md_operandB  = opb_q;
    wb_valid     = (state_q == S_DONE) && !flush;
    wb_rd        = '0;
    wb_data      = '0;
    if (wb_valid) begin
      wb_rd   = exc_q ? EXC_RD : rd_q;
      wb_data = exc_q ? (op_q ? DIV_EXC_CODE : MULT_EXC_CODE) : res_q;
    end
    timeout_flag = timeout_flag_q;
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed scenarios followed by randomized operations.
// The bench models the multdiv unit, and it predicts each writeback from the
// request, the response delay and the cycle budget.
module tb_multdiv_ctrl;

  localparam int TIMEOUT = 40;
  localparam int NEVER   = 1000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_op = 1'b0, flush = 1'b0;
  logic [31:0] req_opA = '0, req_opB = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0, md_resultRDY = 1'b0;
  logic        stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, timeout_flag;
  logic [31:0] md_operandA, md_operandB, wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int failures = 0;
  int mult_pulses = 0;
  int div_pulses = 0;
  bit exp_tflag = 1'b0;

  multdiv_ctrl dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
    .req_opA(req_opA), .req_opB(req_opB), .req_rd(req_rd), .flush(flush),
    .stall(stall), .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV), .md_result(md_result),
    .md_exception(md_exception), .md_resultRDY(md_resultRDY), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .timeout_flag(timeout_flag)
  );

  always #5 clock = ~clock;

  // Count the start pulses that the multdiv unit would see.
  always @(posedge clock) begin
    if (md_ctrl_MULT) mult_pulses++;
    if (md_ctrl_DIV)  div_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic that the modelled multdiv unit returns.
  function automatic logic [31:0] ref_result(input bit op, input logic [31:0] a, input logic [31:0] b);
    if (!op) return a * b;
    if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 32'h0;
    return $signed(a) / $signed(b);
  endfunction

  // One operation, from acceptance to the IDLE cycle after DONE. rdy_k is the
  // BUSY cycle (1-based) in which the unit raises ready. flush_k and rst_k, if
  // non-zero, fall before completion.
  task automatic run_op(input bit op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int rdy_k, input bit exc,
                        input int flush_k, input bit flush_in_done, input bit hold_valid,
                        input bit rdy_in_start, input int rst_k);
    int          m0 = mult_pulses;
    int          d0 = div_pulses;
    logic [31:0] res = ref_result(op, a, b);
    bit          timed_out = !(rdy_k >= 1 && rdy_k <= TIMEOUT);
    int          done_k = timed_out ? TIMEOUT : rdy_k;
    bit          exc_eff = timed_out || exc;
    logic [4:0]  exp_rd = exc_eff ? 5'd30 : rd;
    logic [31:0] exp_data = exc_eff ? (op ? 32'd5 : 32'd4) : res;

    req_valid = 1'b1; req_op = op; req_opA = a; req_opB = b; req_rd = rd;
    #1;
    check("accept_stall", stall, 1'b1);
    @(negedge clock);  // START
    if (!hold_valid) req_valid = 1'b0;
    check("start_mult", md_ctrl_MULT, !op);
    check("start_div", md_ctrl_DIV, op);
    check("start_opA", md_operandA, a);
    check("start_opB", md_operandB, b);
    check("start_stall", stall, 1'b1);
    if (rdy_in_start) begin
      md_resultRDY = 1'b1; md_result = $urandom; md_exception = 1'b1;
    end
    @(negedge clock);  // first BUSY cycle
    md_resultRDY = 1'b0; md_exception = 1'b0;
    check("pulse_count_mult", mult_pulses - m0, {31'd0, !op});
    check("pulse_count_div", div_pulses - d0, {31'd0, op});
    for (int k = 1; k <= TIMEOUT; k++) begin
      check("busy_stall", stall, 1'b1);
      check("busy_wb_valid", wb_valid, 1'b0);
      check("busy_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 2'b00);
      if (k == rst_k) begin
        #2 reset_n = 1'b0;
        req_valid = 1'b0;
        #1;
        exp_tflag = 1'b0;
        check("rst_stall", stall, 1'b0);
        check("rst_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 2'b00);
        check("rst_opA", md_operandA, 32'h0);
        check("rst_opB", md_operandB, 32'h0);
        check("rst_wb", {wb_valid, wb_rd, wb_data}, 38'h0);
        check("rst_tflag", timeout_flag, 1'b0);
        @(negedge clock);
        #3 reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_stall", stall, 1'b0);
        check("post_rst_wb", wb_valid, 1'b0);
        return;
      end
      md_resultRDY = (k == rdy_k);
      md_result    = (k == rdy_k) ? res : $urandom;
      md_exception = (k == rdy_k) ? exc : 1'($urandom_range(0, 1));
      flush        = (k == flush_k);
      @(negedge clock);
      md_resultRDY = 1'b0; md_exception = 1'b0; flush = 1'b0;
      if (k == flush_k) begin
        check("flush_stall", stall, 1'b0);
        check("flush_wb_valid", wb_valid, 1'b0);
        @(negedge clock);
        check("flush_idle_wb", wb_valid, 1'b0);
        return;
      end
      if (k == done_k) break;
    end
    // DONE
    if (flush_in_done) begin
      flush = 1'b1;
      #1;
    end
    if (timed_out) exp_tflag = 1'b1;
    check("done_wb_valid", wb_valid, !flush_in_done);
    check("done_wb_rd", wb_rd, flush_in_done ? 5'd0 : exp_rd);
    check("done_wb_data", wb_data, flush_in_done ? 32'd0 : exp_data);
    check("done_stall", stall, 1'b0);
    check("done_opA", md_operandA, a);
    check("done_tflag", timeout_flag, exp_tflag);
    flush = 1'b0;
    @(negedge clock);  // IDLE gap
    check("idle_wb", {wb_valid, wb_rd, wb_data}, 38'h0);
    check("idle_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 2'b00);
    check("idle_stall", stall, hold_valid);
    check("idle_tflag", timeout_flag, exp_tflag);
  endtask

  initial begin
    // Reset state
    #1;
    check("reset_stall", stall, 1'b0);
    check("reset_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 2'b00);
    check("reset_wb", {wb_valid, wb_rd, wb_data}, 38'h0);
    check("reset_tflag", timeout_flag, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Multiply 7 * -3 = -21, ready 17 cycles after the pulse
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 17, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    // Divide by zero: the unit reports an exception
    run_op(1'b1, 32'd10, 32'd0, 5'd7, 9, 1'b1, 0, 1'b0, 1'b0, 1'b1, 0);
    // Multiply with no ready at all: timeout after 40 BUSY cycles
    run_op(1'b0, 32'd3, 32'd4, 5'd9, NEVER, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    // Divide flushed in its third BUSY cycle, then a fresh multiply
    run_op(1'b1, 32'd100, 32'd7, 5'd11, 20, 1'b0, 3, 1'b0, 1'b0, 1'b0, 0);
    run_op(1'b0, 32'd6, 32'd9, 5'd12, 5, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    // Flush during DONE suppresses the writeback
    run_op(1'b1, 32'd81, 32'd9, 5'd13, 4, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
    // req_valid held across two multiplies; the second has ready on the timeout cycle
    run_op(1'b0, 32'd11, 32'd13, 5'd14, 2, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 5'd0, TIMEOUT, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    req_valid = 1'b0;
    @(negedge clock);

    // Randomized operations
    for (int n = 0; n < 25; n++) begin
      bit          op = 1'($urandom_range(0, 1));
      logic [31:0] a = $urandom;
      logic [31:0] b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      int          rdy_k = $urandom_range(1, 48);
      int          done_k = (rdy_k <= TIMEOUT) ? rdy_k : TIMEOUT;
      bit          exc = (op && b == 0) || ($urandom_range(0, 7) == 0);
      int          flush_k = ($urandom_range(0, 4) == 0 && done_k > 1) ? $urandom_range(1, done_k - 1) : 0;
      bit          fdone = (flush_k == 0) && ($urandom_range(0, 7) == 0);
      run_op(op, a, b, 5'($urandom), rdy_k, exc, flush_k, fdone, 1'b0,
             1'($urandom_range(0, 1)), 0);
    end

    // Asynchronous reset in the middle of BUSY, then a normal operation
    run_op(1'b1, 32'd50, 32'd5, 5'd3, 30, 1'b0, 0, 1'b0, 1'b0, 1'b0, 6);
    run_op(1'b1, 32'd50, 32'd5, 5'd3, 8, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
